// File: rtl/cmd_stream_issuer.sv
// Issues a host-preloaded command program over a 64-bit valid/ready port until a HALT transfers.
// Latency: launch -> first cmd_valid in 2 cycles; 1 command/cycle thereafter; cmd_data held while stalled.
module cmd_stream_issuer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_wr_en,
    input  logic [63:0]   host_wr_data,
    output logic          host_full,
    output logic [AW:0]   host_count,
    input  logic          launch,
    output logic          cmd_valid,
    output logic [63:0]   cmd_data,
    input  logic          cmd_ready,
    input  logic          halted,
    output logic          busy,
    output logic          done,
    output logic [15:0]   issued_count,
    output logic          overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HALT,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    state_t        state_q, state_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [63:0]   cmd_data_q, cmd_data_d;
    logic          halt_loaded_q, halt_loaded_d;
    logic          done_q;
    logic [15:0]   issued_q;
    logic          overflow_q;

    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          hs;
    logic [63:0]   head;

    assign fifo_full = (count_q == DEPTH_C);
    assign push      = host_wr_en && !fifo_full;
    assign hs        = cmd_valid_q && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        cmd_valid_d   = cmd_valid_q;
        cmd_data_d    = cmd_data_q;
        halt_loaded_d = halt_loaded_q;
        case (state_q)
            S_IDLE: begin
                if (launch) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (hs) cmd_valid_d = 1'b0;
                if (hs && (cmd_data_q[63:56] == 8'h00)) begin
                    state_d = S_WAIT_HALT;
                end else if ((!cmd_valid_q || hs) && (count_q != '0) && !halt_loaded_q) begin
                    // Refill the output register; once a HALT is loaded nothing else is fetched.
                    pop           = 1'b1;
                    cmd_valid_d   = 1'b1;
                    cmd_data_d    = head;
                    halt_loaded_d = (head[63:56] == 8'h00);
                end
            end
            S_WAIT_HALT: begin
                if (halted) state_d = S_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= host_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            cmd_valid_q   <= 1'b0;
            cmd_data_q    <= '0;
            halt_loaded_q <= 1'b0;
            done_q        <= 1'b0;
            issued_q      <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            state_q       <= state_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_data_q    <= cmd_data_d;
            halt_loaded_q <= halt_loaded_d;
            done_q        <= (state_q == S_DONE);
            if (hs && (issued_q != 16'hFFFF)) issued_q <= issued_q + 1'b1;
            if (host_wr_en && fifo_full) overflow_q <= 1'b1;
        end
    end

    assign host_full    = fifo_full;
    assign host_count   = count_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_data     = cmd_data_q;
    assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT_HALT);
    assign done         = done_q;
    assign issued_count = issued_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_cmd_stream_issuer.sv
// Bench for cmd_stream_issuer: directed timing scenarios plus randomized programs vs. a queue model.
module tb_cmd_stream_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        host_wr_en = 1'b0;
    logic [63:0] host_wr_data = '0;
    logic        launch = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        halted = 1'b0;
    logic        s_launch = 1'b0;
    logic        s_ready = 1'b0;
    logic        s_halted = 1'b0;

    logic        host_full, cmd_valid, busy, done, overflow;
    logic [4:0]  host_count;
    logic [63:0] cmd_data;
    logic [15:0] issued_count;

    logic        s_host_full, s_cmd_valid, s_busy, s_done, s_overflow;
    logic [2:0]  s_host_count;
    logic [63:0] s_cmd_data;
    logic [15:0] s_issued_count;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] W_NTT  = 64'h0100_0000_0000_0000;
    localparam logic [63:0] W_2    = 64'h0200_0000_0000_0000;
    localparam logic [63:0] W_HALT = 64'h0000_0000_0000_0000;
    localparam logic [63:0] W_LATE = 64'h0180_0000_0000_0000;
    localparam logic [63:0] W_DMA  = 64'h0300_0000_0000_00AB;

    always #5 clk = ~clk;

    cmd_stream_issuer #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
        .host_full(host_full), .host_count(host_count), .launch(launch),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .halted(halted), .busy(busy), .done(done), .issued_count(issued_count),
        .overflow(overflow)
    );

    cmd_stream_issuer #(.DEPTH(4), .AW(2)) dut_small (
        .clk(clk), .rst(rst), .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
        .host_full(s_host_full), .host_count(s_host_count), .launch(s_launch),
        .cmd_valid(s_cmd_valid), .cmd_data(s_cmd_data), .cmd_ready(s_ready),
        .halted(s_halted), .busy(s_busy), .done(s_done), .issued_count(s_issued_count),
        .overflow(s_overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        host_wr_en = 1'b0;
        launch     = 1'b0;
        cmd_ready  = 1'b0;
        halted     = 1'b0;
        rst        = 1'b1;
        step();
        rst        = 1'b0;
    endtask

    task automatic push(input logic [63:0] w);
        host_wr_en   = 1'b1;
        host_wr_data = w;
        step();
        host_wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cmd_valid, host_full, busy, done, overflow} !== 5'b0 || cmd_data !== 64'h0 ||
            host_count !== 5'd0 || issued_count !== 16'd0) begin
            errors++;
            $display("FAIL reset: valid=%b full=%b busy=%b done=%b ovf=%b data=%h cnt=%0d iss=%0d (all zero required)",
                     cmd_valid, host_full, busy, done, overflow, cmd_data, host_count, issued_count);
        end
    endtask

    task automatic test_basic();
        logic [63:0] exp_w [3];
        exp_w[0] = W_NTT; exp_w[1] = W_2; exp_w[2] = W_HALT;
        do_reset();
        push(W_NTT); push(W_2); push(W_HALT);
        cmd_ready = 1'b1;
        launch = 1'b1;          // cycle T
        step();                 // T+1
        launch = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_t1: valid=%b busy=%b required valid=0 busy=1", cmd_valid, busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();             // T+2 .. T+4
            checks++;
            if (cmd_valid !== 1'b1 || cmd_data !== exp_w[i]) begin
                errors++;
                $display("FAIL basic_word%0d: valid=%b data=%h required valid=1 data=%h", i, cmd_valid, cmd_data, exp_w[i]);
            end
        end
        step();                 // T+5
        checks++;
        if (cmd_valid !== 1'b0 || issued_count !== 16'd3 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_t5: valid=%b iss=%0d busy=%b done=%b required 0/3/1/0", cmd_valid, issued_count, busy, done);
        end
        step();                 // T+6
        halted = 1'b1;
        step();                 // T+7
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_t7_done: done=%b required 0", done);
        end
        step();                 // T+8
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_t8: done=%b busy=%b required done=1 busy=0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_w [3];
        int          got;
        exp_w[0] = W_NTT; exp_w[1] = W_2; exp_w[2] = W_HALT;
        do_reset();
        push(W_NTT); push(W_2); push(W_HALT);
        launch = 1'b1;
        step();
        launch = 1'b0;
        step();                 // first valid
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_data !== W_NTT || issued_count !== 16'd0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h iss=%0d required 1/%h/0", i, cmd_valid, cmd_data, issued_count, W_NTT);
            end
            step();
        end
        cmd_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (cmd_valid) begin
                checks++;
                if (cmd_data !== exp_w[got]) begin
                    errors++;
                    $display("FAIL bp_order%0d: data=%h required %h", got, cmd_data, exp_w[got]);
                end
                got++;
            end
            step();
        end
        checks++;
        if (got !== 3 || issued_count !== 16'd3) begin
            errors++;
            $display("FAIL bp_count: seen=%0d iss=%0d required 3/3", got, issued_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) push(64'h0500_0000_0000_0000 + 64'(i));
        checks++;
        if (s_host_full !== 1'b1 || s_host_count !== 3'd4 || s_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full: full=%b cnt=%0d ovf=%b required 1/4/0", s_host_full, s_host_count, s_overflow);
        end
        push(64'h0500_0000_0000_0004);
        checks++;
        if (s_host_full !== 1'b1 || s_host_count !== 3'd4 || s_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: full=%b cnt=%0d ovf=%b required 1/4/1", s_host_full, s_host_count, s_overflow);
        end
    endtask

    task automatic test_underrun();
        do_reset();
        cmd_ready = 1'b1;
        launch = 1'b1;          // T
        step();
        launch = 1'b0;
        repeat (4) step();      // T+5
        host_wr_en   = 1'b1;
        host_wr_data = W_LATE;
        step();                 // T+6
        host_wr_en   = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL under_t6: valid=%b required 0", cmd_valid);
        end
        step();                 // T+7
        checks++;
        if (cmd_valid !== 1'b1 || cmd_data !== W_LATE) begin
            errors++;
            $display("FAIL under_t7: valid=%b data=%h required 1/%h", cmd_valid, cmd_data, W_LATE);
        end
        step();                 // T+8
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || issued_count !== 16'd1) begin
            errors++;
            $display("FAIL under_t8: valid=%b busy=%b done=%b iss=%0d required 0/1/0/1", cmd_valid, busy, done, issued_count);
        end
    endtask

    task automatic test_halt_mid();
        int dma_seen = 0;
        do_reset();
        push(W_NTT); push(W_HALT); push(W_DMA);
        cmd_ready = 1'b1;
        halted    = 1'b1;       // held high early: must be ignored until WAIT_HALT
        launch    = 1'b1;
        step();
        launch    = 1'b0;
        for (int c = 0; c < 30 && done !== 1'b1; c++) begin
            if (cmd_data === W_DMA) dma_seen++;
            step();
        end
        checks++;
        if (done !== 1'b1 || issued_count !== 16'd2 || host_count !== 5'd1 || dma_seen != 0) begin
            errors++;
            $display("FAIL halt_mid: done=%b iss=%0d cnt=%0d dma_seen=%0d required 1/2/1/0", done, issued_count, host_count, dma_seen);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        do_reset();
        push(W_NTT); push(W_2); push(W_HALT);
        launch = 1'b1;
        step();
        launch = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || host_count !== 5'd0 || issued_count !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid: valid=%b cnt=%0d iss=%0d busy=%b required 0/0/0/0", cmd_valid, host_count, issued_count, busy);
        end
        cmd_ready = 1'b1;
        launch = 1'b1;
        step();
        launch = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (cmd_valid !== 1'b0 || issued_count !== 16'd0 || busy !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_empty_launch: %0d bad cycles, required 0 (no valid, no issue, busy)", bad);
        end
    endtask

    task automatic test_random(input int iters);
        logic [63:0] prog[$];
        logic [63:0] exp_q[$];
        logic [63:0] got[$];
        logic [63:0] w, prev_data;
        logic        has_halt, prev_stall;
        int          len, stab_bad;
        for (int it = 0; it < iters; it++) begin
            prog.delete(); exp_q.delete(); got.delete();
            do_reset();
            len = $urandom_range(1, 12);
            has_halt = 1'b0;
            for (int i = 0; i < len; i++) begin
                w = {$urandom(), $urandom()};
                w[63:56] = 8'($urandom_range(0, 4));
                prog.push_back(w);
            end
            foreach (prog[i]) begin
                if (!has_halt) exp_q.push_back(prog[i]);
                if (prog[i][63:56] == 8'h00) has_halt = 1'b1;
                push(prog[i]);
            end
            checks++;
            if (host_count !== 5'(len)) begin
                errors++;
                $display("FAIL rnd%0d_preload: cnt=%0d required %0d", it, host_count, len);
            end
            launch = 1'b1;
            step();
            launch = 1'b0;
            prev_stall = 1'b0;
            prev_data  = '0;
            stab_bad   = 0;
            for (int c = 0; c < 200 && done !== 1'b1; c++) begin
                if (prev_stall && (cmd_valid !== 1'b1 || cmd_data !== prev_data)) stab_bad++;
                cmd_ready = ($urandom_range(0, 2) != 0);
                halted    = ($urandom_range(0, 3) == 0);
                if (cmd_valid && cmd_ready) got.push_back(cmd_data);
                prev_stall = cmd_valid && !cmd_ready;
                prev_data  = cmd_data;
                step();
            end
            checks++;
            if (stab_bad != 0) begin
                errors++;
                $display("FAIL rnd%0d_stable: %0d stalled cycles changed, required 0", it, stab_bad);
            end
            checks++;
            if (got.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rnd%0d_len: handshakes=%0d required %0d", it, got.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (got[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rnd%0d_word%0d: got=%h required %h", it, i, got[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (issued_count !== 16'(exp_q.size()) || host_count !== 5'(len - exp_q.size()) ||
                done !== has_halt) begin
                errors++;
                $display("FAIL rnd%0d_final: iss=%0d cnt=%0d done=%b required %0d/%0d/%b",
                         it, issued_count, host_count, done, exp_q.size(), len - exp_q.size(), has_halt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_underrun();
        test_halt_mid();
        test_reset_mid();
        test_random(25);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_stream_issuer.md
Name: cmd_stream_issuer

Overview:
- Initiator side of the 64-bit command valid/ready interface; drives the command processor's cmd_valid/cmd_data/cmd_ready port.
- Host software preloads a command program into an internal FIFO, then pulses launch.
- The block issues commands in order, honouring backpressure.
- Issue stops after a HALT opcode is transferred. The block then waits for the processor's halted flag and reports done.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- AW, 4, log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- host_wr_en  in  1  push host_wr_data into FIFO
- host_wr_data  in  64  command word; opcode [63:56], 0x00 = HALT
- host_full  out  1  FIFO full (registered count == DEPTH)
- host_count  out  AW+1  current FIFO occupancy
- launch  in  1  start issuing (one-cycle pulse, honoured only in IDLE)
- cmd_valid  out  1  command valid to processor
- cmd_data  out  64  command word to processor
- cmd_ready  in  1  processor accepts
- halted  in  1  processor halted flag (sticky in processor)
- busy  out  1  state is ISSUE or WAIT_HALT
- done  out  1  HALT accepted and halted observed; sticky until rst
- issued_count  out  16  handshakes completed; saturates at 0xFFFF
- overflow  out  1  sticky; a push was dropped because the FIFO was full

Behaviour:
- Reset values:
  - FIFO emptied; host_count = 0; host_full = 0.
  - cmd_valid = 0; cmd_data = 0.
  - busy = 0; done = 0; issued_count = 0; overflow = 0; state = IDLE.
- Reset asserted mid-operation discards everything, including FIFO contents and any pending cmd_valid.

FIFO:
- Circular buffer with AW-bit read/write pointers that wrap modulo DEPTH.
- Push is accepted when host_wr_en = 1 and the registered count < DEPTH.
- A push when full is dropped and sets overflow, even if a pop occurs the same cycle.
- Pushes are accepted in every state.
- A pop and a push in the same cycle leave the count unchanged.
- A pop requires the registered count > 0. A word pushed in cycle T is poppable no earlier than T+1.

State machine:
- IDLE:
  - cmd_valid = 0.
  - launch = 1 -> ISSUE next cycle. launch in any other state is ignored.
- ISSUE:
  - Output register: cmd_data/cmd_valid are registered. On a pop, cmd_data <= head and cmd_valid <= 1 next cycle.
  - Pop when (cmd_valid = 0 or handshake this cycle) and FIFO non-empty and no HALT has been loaded into the output register.
  - Handshake = cmd_valid & cmd_ready. issued_count increments by 1 per handshake, saturating.
  - Back-to-back: a handshake with a non-empty FIFO reloads the register the same cycle. cmd_valid stays high, giving 1 command per cycle.
  - Handshake with an empty FIFO -> cmd_valid = 0 next cycle (underrun). Remain in ISSUE and resume when data arrives.
  - While cmd_valid = 1 and cmd_ready = 0, cmd_data is held stable.
  - Handshake of a word with opcode 0x00 -> WAIT_HALT. cmd_valid = 0 next cycle, and no further pops occur.
- WAIT_HALT:
  - halted = 1 -> DONE; done = 1 in the following cycle.
- DONE:
  - Terminal; done = 1, busy = 0. Only rst exits.
  - Remaining FIFO entries are retained and never issued.

Timing and other rules:
- Launch latency: launch at cycle T gives state = ISSUE at T+1, first pop at T+1, and cmd_valid = 1 at T+2 when the FIFO is non-empty at T+1.
- halted asserted while not in WAIT_HALT is ignored.

Test Plan:
- Push 0x0100_0000_0000_0000, 0x0200_0000_0000_0000, 0x0000_0000_0000_0000; cmd_ready = 1; launch at T -> cmd_valid high T+2..T+4 with the three words in order; issued_count = 3; busy = 1; drive halted at T+6 -> done = 1 at T+8, busy = 0.
- Same program with cmd_ready = 0 for 5 cycles after the first valid -> cmd_valid stays 1 and cmd_data stays 0x0100_0000_0000_0000; issued_count does not change until ready rises; order is preserved.
- DEPTH = 4: push 5 words in consecutive cycles with no launch -> host_full = 1 after the 4th push; 5th dropped; overflow = 1; host_count = 4.
- Launch with empty FIFO; push 0x0180_0000_0000_0000 at T+5 -> cmd_valid = 1 at T+7 with that word; after its handshake cmd_valid = 0 and state remains ISSUE.
- Push NTT, HALT, DMA; run to done -> only 2 handshakes; host_count = 1; DMA word never driven on cmd_data.
- Assert rst while cmd_valid = 1 mid-program -> next cycle cmd_valid = 0, host_count = 0, issued_count = 0, state IDLE; a subsequent launch with empty FIFO issues nothing.
